// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int              XLEN                 = 32;
  localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
  localparam logic [XLEN-1:0] PC_PLUS8             = 32'd8;
  localparam logic [XLEN-1:0] BUBBLE_INSTR_DEFAULT = 32'hF000_0000;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port between fetch stage and memory.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic            IReqValid;
  logic [XLEN-1:0] IReqAddr;
  logic            IReqReady;
  logic            IRespValid;
  logic [XLEN-1:0] IRespData;

  modport master (
    output IReqValid,
    output IReqAddr,
    input  IReqReady,
    input  IRespValid,
    input  IRespData
  );

  modport slave (
    input  IReqValid,
    input  IReqAddr,
    output IReqReady,
    output IRespValid,
    output IRespData
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO with clear; registered output, no fall-through.
module fetch_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // a full buffer can still accept a word when the head leaves this cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with credit-limited issue, in-order response buffering,
// stale-response discard after redirects, and the IF/ID pipeline register.
//
//   state | meaning
//   RUN   | no stale responses pending; every response is buffered
//   DRAIN | drop_q > 0; responses are discarded until drop_q reaches zero
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              BUF_DEPTH    = 2,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] BranchTargetE,
  input  logic            PCSrcW,
  input  logic [XLEN-1:0] ResultW,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus8D,
  output logic            InstrValidD
);

  localparam int               CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]   CREDIT = (CNT_W + 1)'(BUF_DEPTH);

  logic [XLEN-1:0]   pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  drop_next;
  fetch_state_e      state_q;

  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              resp_take;
  logic              discard;
  logic              resp_keep;
  logic              req_valid;
  logic              req_fire;
  logic              load_head;
  logic [CNT_W:0]    in_flight;

  logic [2*XLEN-1:0] buf_head;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic [XLEN-1:0]   addr_head;
  logic [CNT_W-1:0]  addr_count;
  logic              addr_full;
  logic              addr_empty;
  logic              unused_flags;

  // PCSrcW belongs to the older instruction, so it wins over a branch
  assign redirect  = PCSrcW | BranchTakenE;
  assign target    = PCSrcW ? ResultW : BranchTargetE;

  assign resp_take = imem.IRespValid && (outstanding_q != '0);
  assign discard   = (state_q == DRAIN);
  assign resp_keep = resp_take && !discard && !redirect;

  // stale requests still hold credit: they are counted inside outstanding_q
  assign in_flight = {1'b0, buf_count} + {1'b0, outstanding_q};
  assign req_valid = !reset && !StallF && !redirect && (in_flight < CREDIT);
  assign req_fire  = req_valid && imem.IReqReady;
  assign load_head = !redirect && !FlushD && !StallD && !buf_empty;

  assign imem.IReqValid = req_valid;
  assign imem.IReqAddr  = pc_q;

  assign unused_flags = ^{addr_count, addr_full, addr_empty, buf_full};

  always_comb begin
    drop_next = drop_q;
    if (redirect)
      drop_next = outstanding_q - CNT_W'(resp_take);
    else if (resp_take && discard)
      drop_next = drop_q - CNT_W'(1);
  end

  fetch_buffer #(.WIDTH(2 * XLEN), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk   (clk),
    .reset (reset),
    .push  (resp_keep),
    .pop   (load_head),
    .clear (redirect),
    .din   ({imem.IRespData, addr_head}),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // fetch PCs of live requests, consumed in response order
  fetch_buffer #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_addr_buf (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (resp_take && !discard),
    .clear (redirect),
    .din   (pc_q),
    .dout  (addr_head),
    .count (addr_count),
    .full  (addr_full),
    .empty (addr_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      state_q       <= RUN;
      InstrD        <= BUBBLE_INSTR;
      PCPlus8D      <= '0;
      InstrValidD   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_take);
      drop_q        <= drop_next;

      case (state_q)
        RUN:     if (drop_next != '0) state_q <= DRAIN;
        DRAIN:   if (drop_next == '0) state_q <= RUN;
        default: state_q <= RUN;
      endcase

      if (redirect)      pc_q <= target;
      else if (req_fire) pc_q <= pc_q + PC_STEP;

      if (redirect || FlushD) begin
        InstrD      <= BUBBLE_INSTR;
        PCPlus8D    <= '0;
        InstrValidD <= 1'b0;
      end else if (StallD) begin
        InstrD      <= InstrD;
      end else if (!buf_empty) begin
        InstrD      <= buf_head[2*XLEN-1:XLEN];
        PCPlus8D    <= buf_head[XLEN-1:0] + PC_PLUS8;
        InstrValidD <= 1'b1;
      end else begin
        InstrD      <= BUBBLE_INSTR;
        PCPlus8D    <= '0;
        InstrValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle tables plus hand-written redirect,
// wrap and reset sequences against a fixed-latency in-order memory model.
module tb_fetch_stage;

  localparam logic [31:0] BUBBLE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
  logic [31:0] BranchTargetE, ResultW;
  logic [31:0] InstrD, PCPlus8D;
  logic        InstrValidD;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .BUF_DEPTH    (2),
    .BUBBLE_INSTR (BUBBLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .imem          (imem),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .InstrValidD   (InstrValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        stall_f, stall_d, flush_d, ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t       pend[$];
  vec_t        vecs[$];
  int          mem_lat = 1;
  int          cyc = 0;
  int          base = 0;
  int          checks = 0;
  int          passed = 0;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_instr, obs_p8;
  int          obs_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h3C5A_0003;
  endfunction

  function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic rdy,
                              input logic rv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] pc);
    vec_t v;
    v.stall_f = sf; v.stall_d = sd; v.flush_d = fd; v.ready = rdy;
    v.exp_rv = rv; v.exp_addr = addr; v.exp_iv = iv; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock cycle: observe mid-cycle, run the memory model, then step past the edge.
  task automatic tick();
    @(negedge clk);
    obs_rv    = imem.IReqValid;
    obs_addr  = imem.IReqAddr;
    obs_iv    = InstrValidD;
    obs_instr = InstrD;
    obs_p8    = PCPlus8D;
    obs_cyc   = cyc - base;
    if (imem.IReqValid && imem.IReqReady)
      pend.push_back('{addr: imem.IReqAddr, due: cyc + mem_lat});
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem.IRespValid = 1'b1;
      imem.IRespData  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem.IRespValid = 1'b0;
      imem.IRespData  = 32'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit keep_pend);
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    BranchTargetE = 32'h0; ResultW = 32'h0;
    imem.IReqReady = 1'b1;
    tick();
    check("reset IReqValid", {31'b0, obs_rv}, 32'h0);
    tick();
    check("reset InstrD", InstrD, BUBBLE);
    check("reset InstrValidD", {31'b0, InstrValidD}, 32'h0);
    check("reset PCPlus8D", PCPlus8D, 32'h0);
    if (!keep_pend) pend.delete();
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic run_vecs(input string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      StallF = vecs[i].stall_f;
      StallD = vecs[i].stall_d;
      FlushD = vecs[i].flush_d;
      imem.IReqReady = vecs[i].ready;
      tick();
      check($sformatf("%s c%0d IReqValid", tname, i), {31'b0, obs_rv}, {31'b0, vecs[i].exp_rv});
      if (vecs[i].exp_rv)
        check($sformatf("%s c%0d IReqAddr", tname, i), obs_addr, vecs[i].exp_addr);
      check($sformatf("%s c%0d InstrValidD", tname, i), {31'b0, obs_iv}, {31'b0, vecs[i].exp_iv});
      check($sformatf("%s c%0d InstrD", tname, i), obs_instr,
            vecs[i].exp_iv ? mem_word(vecs[i].exp_pc) : BUBBLE);
      check($sformatf("%s c%0d PCPlus8D", tname, i), obs_p8,
            vecs[i].exp_iv ? vecs[i].exp_pc + 32'd8 : 32'h0);
    end
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; imem.IReqReady = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc, input int exp_cyc);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (obs_iv) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s: got no valid InstrD in 20 cycles, expected pc %h", name, pc);
    end else begin
      check({name, " cycle"}, obs_cyc, exp_cyc);
      check({name, " InstrD"}, obs_instr, mem_word(pc));
      check({name, " PCPlus8D"}, obs_p8, pc + 32'd8);
    end
  endtask

  initial begin
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    BranchTargetE = 32'h0; ResultW = 32'h0;
    imem.IReqReady = 1'b1; imem.IRespValid = 1'b0; imem.IRespData = 32'h0;

    // free-running 1-cycle memory, then IReqReady low for 3 cycles at 0x10
    mem_lat = 1;
    do_reset(1'b0);
    vecs.delete();
    vecs.push_back(mk(0,0,0,1, 1,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h04, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h08, 1,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h0C, 1,32'h04));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,0, 1,32'h10, 1,32'h08));
    vecs.push_back(mk(0,0,0,0, 1,32'h10, 1,32'h0C));
    vecs.push_back(mk(0,0,0,0, 1,32'h10, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h10, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h14, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h18, 1,32'h10));
    vecs.push_back(mk(0,0,0,1, 1,32'h1C, 1,32'h14));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    run_vecs("stream");

    // StallD with a full buffer, then FlushD together with StallD
    do_reset(1'b0);
    vecs.delete();
    vecs.push_back(mk(0,0,0,1, 1,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h04, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    vecs.push_back(mk(0,1,0,1, 1,32'h08, 1,32'h00));
    vecs.push_back(mk(0,1,0,1, 0,32'h00, 1,32'h00));
    vecs.push_back(mk(0,1,0,1, 0,32'h00, 1,32'h00));
    vecs.push_back(mk(0,1,0,1, 0,32'h00, 1,32'h00));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 1,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h0C, 1,32'h04));
    vecs.push_back(mk(0,1,1,1, 1,32'h10, 1,32'h08));
    vecs.push_back(mk(0,0,0,1, 0,32'h00, 0,32'h00));
    vecs.push_back(mk(0,0,0,1, 1,32'h14, 1,32'h0C));
    vecs.push_back(mk(0,0,0,1, 1,32'h18, 1,32'h10));
    run_vecs("stall");

    // branch with two requests in flight on a 3-cycle memory
    mem_lat = 3;
    do_reset(1'b0);
    tick();
    tick();
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    tick();
    check("branch redirect IReqValid", {31'b0, obs_rv}, 32'h0);
    BranchTakenE = 1'b0;
    tick();
    check("branch drain IReqValid", {31'b0, obs_rv}, 32'h0);
    tick();
    check("branch first IReqValid", {31'b0, obs_rv}, 32'h1);
    check("branch first IReqAddr", obs_addr, 32'h100);
    wait_valid("branch target", 32'h100, 9);
    wait_valid("branch target+4", 32'h104, 10);

    // PCSrcW and BranchTakenE together: writeback wins
    mem_lat = 1;
    do_reset(1'b0);
    PCSrcW = 1'b1; ResultW = 32'h200;
    BranchTakenE = 1'b1; BranchTargetE = 32'h300;
    tick();
    check("both redirect IReqValid", {31'b0, obs_rv}, 32'h0);
    PCSrcW = 1'b0; BranchTakenE = 1'b0;
    tick();
    check("both first IReqValid", {31'b0, obs_rv}, 32'h1);
    check("both first IReqAddr", obs_addr, 32'h200);
    wait_valid("both target", 32'h200, 4);
    wait_valid("both target+4", 32'h204, 5);

    // PC wrap from 0xFFFFFFFC to 0
    do_reset(1'b0);
    BranchTakenE = 1'b1; BranchTargetE = 32'hFFFF_FFFC;
    tick();
    BranchTakenE = 1'b0;
    tick();
    check("wrap IReqAddr top", obs_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap IReqValid zero", {31'b0, obs_rv}, 32'h1);
    check("wrap IReqAddr zero", obs_addr, 32'h0);
    wait_valid("wrap last", 32'hFFFF_FFFC, 4);
    wait_valid("wrap first", 32'h0, 5);

    // reset with requests in flight; late responses must be ignored
    mem_lat = 3;
    do_reset(1'b0);
    tick();
    tick();
    do_reset(1'b1);
    wait_valid("post-reset first", 32'h0, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
